// File: rtl/fp_dot_accum.sv
// Streaming float32 dot-product accumulation controller.
// Drives an external combinational fp_adder with the running sum and the incoming
// product, registers its result once per accepted element, and presents the final
// sum (optionally ReLU-clamped) on a valid/ready output port.
module fp_dot_accum #(
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned LEN_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             relu_en,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [LEN_W-1:0] elem_cnt
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOut
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             relu_q, relu_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      out_q, out_d;

    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] cnt_inc;
    logic             beat;
    logic             last_beat;
    logic             sum_is_nan;
    logic             relu_zero;

    // Requests above the supported length are clamped rather than rejected.
    assign len_clamped = (vec_len > MaxLen) ? MaxLen : vec_len;
    assign cnt_inc     = cnt_q + LEN_W'(1);

    // The adder sees the running sum and the live input every cycle.
    assign add_a = acc_q;
    assign add_b = in_data;

    // in_ready drops as soon as the requested count is reached, so cnt saturates at len.
    assign in_ready  = (state_q == StAccum) && (cnt_q < len_q);
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (cnt_inc == len_q);

    // NaN results bypass ReLU so that upstream faults stay visible downstream.
    assign sum_is_nan = (add_result[30:23] == 8'hFF) && (add_result[22:0] != '0);
    assign relu_zero  = relu_q && add_result[31] && !sum_is_nan;

    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign out_data  = out_q;
    assign elem_cnt  = cnt_q;

    // Next-state and datapath update for the IDLE -> ACCUM -> OUT -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        relu_d  = relu_q;
        acc_d   = acc_q;
        out_d   = out_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d  = len_clamped;
                    relu_d = relu_en;
                    acc_d  = 32'h0;
                    cnt_d  = '0;
                    if (len_clamped == '0) begin
                        out_d   = 32'h0;
                        state_d = StOut;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (beat) begin
                    acc_d = add_result;
                    cnt_d = cnt_inc;
                    if (last_beat) begin
                        out_d   = relu_zero ? 32'h0 : add_result;
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                // start is deliberately not looked at here; a new run needs IDLE.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            relu_q  <= 1'b0;
            acc_q   <= 32'h0;
            out_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_fp_dot_accum.sv
// Self-checking bench for fp_dot_accum with an ideal float32 adder model.
module tb_fp_dot_accum;

    localparam int MAX_LEN = 1024;
    localparam int LEN_W   = 11;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             relu_en;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_result;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;
    logic             busy;
    logic [LEN_W-1:0] elem_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] in_q[$];

    fp_dot_accum #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .vec_len   (vec_len),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_result(add_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .elem_cnt  (elem_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // float32 <-> real conversions; stimulus avoids denormals and uses exact values.
    function automatic real f2r(input logic [31:0] a);
        logic [63:0] d;
        if (a[30:23] == 8'h00) return 0.0;
        d = {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] f32_add(input logic [31:0] a, input logic [31:0] b);
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == 8'hFF) return a;
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Ideal combinational fp_adder.
    always_comb add_result = f32_add(add_a, add_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    // One full run: start, stream in_q, optional output back-pressure, handshake.
    task automatic run(input int len, input bit relu, input bit gaps, input int hold,
                       input logic [31:0] expv, input string tag);
        int  eff;
        int  idx;
        int  budget;
        bit  v;
        bit  took;
        bit  first;
        eff = (len > MAX_LEN) ? MAX_LEN : len;
        @(posedge clk); #1;
        start   = 1'b1;
        vec_len = LEN_W'(len);
        relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".rdy0"}, 32'(in_ready), 32'(eff > 0));
        idx    = 0;
        budget = 0;
        first  = 1'b1;
        while (out_valid !== 1'b1 && budget < 5000) begin
            v        = !(gaps && $urandom_range(0, 2) == 0);
            in_valid = v;
            in_data  = (idx < in_q.size()) ? in_q[idx] : 32'h3F800000;
            if (first) begin
                chk({tag, ".acc0"}, add_a, 32'h0);
                first = 1'b0;
            end
            took = v && in_ready;
            @(posedge clk); #1;
            budget++;
            if (took) begin
                idx++;
                if (idx == eff) chk({tag, ".lat"}, 32'(out_valid), 32'd1);
            end
        end
        in_valid = 1'b0;
        if (budget >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no out_valid, want out_valid within 5000", tag);
        end
        chk({tag, ".beats"}, 32'(idx), 32'(eff));
        chk({tag, ".cnt"}, 32'(elem_cnt), 32'(eff));
        chk({tag, ".rdy_out"}, 32'(in_ready), 32'd0);
        chk({tag, ".data"}, out_data, expv);
        for (int h = 0; h < hold; h++) begin
            start   = (h == 2);
            vec_len = LEN_W'(3);
            @(posedge clk); #1;
            chk({tag, ".hold_v"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_d"}, out_data, expv);
        end
        // Handshake with start asserted at the same time: start must be ignored.
        out_ready = 1'b1;
        start     = (hold > 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, ".done_v"}, 32'(out_valid), 32'd0);
        chk({tag, ".done_b"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".idle_b"}, 32'(busy), 32'd0);
    endtask

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             relu;
        logic [3:0][31:0] data;
        logic [31:0]      expv;
    } vec_t;

    function automatic vec_t mk(input int len, input bit relu, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3, input logic [31:0] e);
        vec_t t;
        t.len  = LEN_W'(len);
        t.relu = relu;
        t.data = {d3, d2, d1, d0};
        t.expv = e;
        return t;
    endfunction

    vec_t tbl[7];

    initial begin
        int          sum;
        int          len;
        int          val;
        bit          relu;
        logic [31:0] expv;

        tbl[0] = mk(3, 0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 32'h40C00000);
        tbl[1] = mk(2, 0, 32'h3F800000, 32'hC0400000, 32'h0, 32'h0, 32'hC0000000);
        tbl[2] = mk(2, 1, 32'h3F800000, 32'hC0400000, 32'h0, 32'h0, 32'h00000000);
        tbl[3] = mk(0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000000);
        tbl[4] = mk(1, 1, 32'hFFC00001, 32'h0, 32'h0, 32'h0, 32'hFFC00001);
        tbl[5] = mk(2, 1, 32'h40000000, 32'h3F800000, 32'h0, 32'h0, 32'h40400000);
        tbl[6] = mk(4, 0, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                    32'hC0800000);

        reset     = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        relu_en   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd0);
        chk("rst.oval", 32'(out_valid), 32'd0);
        chk("rst.odata", out_data, 32'h0);
        chk("rst.cnt", 32'(elem_cnt), 32'd0);
        reset = 1'b1;

        // in_valid in IDLE must be ignored.
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("idle.rdy", 32'(in_ready), 32'd0);
        chk("idle.cnt", 32'(elem_cnt), 32'd0);
        in_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            in_q.delete();
            for (int j = 0; j < int'(tbl[i].len); j++) in_q.push_back(tbl[i].data[j]);
            run(int'(tbl[i].len), tbl[i].relu, 1'b0, 0, tbl[i].expv, $sformatf("tbl%0d", i));
        end

        // Gapped input with output back-pressure and start pulsed in OUT.
        in_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        run(4, 1'b0, 1'b1, 5, 32'h41200000, "gaps");

        // Reset mid-run after two of four beats.
        @(posedge clk); #1;
        start   = 1'b1;
        vec_len = LEN_W'(4);
        relu_en = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h40400000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid.cnt2", 32'(elem_cnt), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.rdy", 32'(in_ready), 32'd0);
        chk("mid.oval", 32'(out_valid), 32'd0);
        chk("mid.cnt", 32'(elem_cnt), 32'd0);
        chk("mid.acc", add_a, 32'h0);
        chk("mid.odata", out_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        in_q  = '{32'h3F800000, 32'h3F800000};
        run(2, 1'b0, 1'b0, 0, 32'h40000000, "after_rst");

        // Oversized length clamps to MAX_LEN.
        in_q.delete();
        for (int j = 0; j < MAX_LEN; j++) in_q.push_back(32'h3F800000);
        run(2000, 1'b0, 1'b0, 1, 32'h44800000, "clamp");

        // Randomized runs against an integer-valued reference sum.
        for (int r = 0; r < 20; r++) begin
            len  = $urandom_range(1, 8);
            relu = 1'($urandom_range(0, 1));
            sum  = 0;
            in_q.delete();
            for (int j = 0; j < len; j++) begin
                val = int'($urandom_range(0, 40)) - 20;
                sum += val;
                in_q.push_back(r2f(real'(val)));
            end
            expv = (relu && sum < 0) ? 32'h0 : r2f(real'(sum));
            run(len, relu, 1'b1, int'($urandom_range(0, 3)), expv, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
